// File: rtl/quad_dec.sv
// quad_dec: quadrature phase decoder with synchronizer, glitch filter
// and wrapping position counter.
module quad_dec #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FILT_LEN - 1);

  localparam int INIT_LEN = SYNC_STAGES + FILT_LEN;
  localparam int IW = $clog2(INIT_LEN + 1);
  localparam logic [IW-1:0] IMAX = IW'(INIT_LEN - 1);

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  // Channel index 1 is phase A, index 0 is phase B, so {x[1],x[0]} = {a,b}
  logic [SYNC_STAGES-1:0] sync_a;
  logic [SYNC_STAGES-1:0] sync_b;
  logic [1:0]             s;
  logic [1:0]             f;
  logic [1:0]             p;
  logic [0:0]             state;
  logic [IW-1:0]          init_cnt;
  logic                   run;
  logic                   up;
  logic                   dn;
  logic                   bad;
  logic                   active;
  logic [CNT_W-1:0]       pos_nxt;

  assign s   = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
  assign run = (state == S_RUN);

  // Metastability chains for both phase inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], a_in};
      sync_b <= {sync_b[SYNC_STAGES-2:0], b_in};
    end
  end

  // Start-up window: inputs pass straight through until the pipeline is full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      unique case (state)
        S_INIT: begin
          if (init_cnt == IMAX) begin
            state <= S_RUN;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_filt
    logic [FW-1:0] fcnt;

    // A level must persist FILT_LEN cycles before the filtered bit follows it
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        f[c] <= 1'b0;
        fcnt <= '0;
      end else if (!run) begin
        f[c] <= s[c];
        fcnt <= '0;
      end else if (s[c] == f[c]) begin
        fcnt <= '0;
      end else if (fcnt == FMAX) begin
        f[c] <= s[c];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Previous filtered state, tracked even while decoding is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= 2'b00;
    end else if (!run) begin
      p <= s;
    end else begin
      p <= f;
    end
  end

  // Gray-code transition classification from previous to current state
  always_comb begin
    up  = 1'b0;
    dn  = 1'b0;
    bad = 1'b0;
    unique case ({p, f})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: up  = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: dn  = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
      default: ;
    endcase
  end

  assign active = run && ena;

  // Next position: clear has priority over any counted step
  always_comb begin
    pos_nxt = pos;
    if (clr) begin
      pos_nxt = '0;
    end else if (active && up) begin
      pos_nxt = pos + 1'b1;
    end else if (active && dn) begin
      pos_nxt = pos - 1'b1;
    end
  end

  // Registered position, step pulse and direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  <= '0;
      step <= 1'b0;
      dir  <= 1'b0;
    end else begin
      pos  <= pos_nxt;
      step <= active && (up || dn);
      if (active && (up || dn)) begin
        dir <= up;
      end
    end
  end

  // Sticky illegal-transition flag; a new error beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (active && bad) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_dec.sv
// tb_quad_dec: directed and randomized checks of quad_dec against a
// phase-index reference model.
module tb_quad_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        a_in;
  logic        b_in;
  logic        clr;
  logic        err_clr;
  logic [15:0] pos;
  logic        step;
  logic        dir;
  logic        err;

  int total = 0;
  int bad = 0;

  logic [1:0]  mlvl;
  logic [15:0] mpos;
  logic        mdir;
  logic        merr;

  quad_dec #(
    .CNT_W(16),
    .SYNC_STAGES(2),
    .FILT_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .a_in(a_in),
    .b_in(b_in),
    .clr(clr),
    .err_clr(err_clr),
    .pos(pos),
    .step(step),
    .dir(dir),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Position of a {a,b} level along the forward cycle 00,01,11,10
  function automatic int gidx(input logic [1:0] l);
    case (l)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    chk({tag, "_pos"}, 32'(pos), 32'(mpos));
    chk({tag, "_dir"}, 32'(dir), 32'(mdir));
    chk({tag, "_err"}, 32'(err), 32'(merr));
  endtask

  // Apply a new level at a falling edge and hold it; the step pulse is
  // expected exactly after the 7th rising edge (edge 6)
  task automatic move(input logic [1:0] lvl, input int hold,
                      input bit do_clr, input bit do_eclr);
    int d;
    bit cnt;
    d = (gidx(lvl) - gidx(mlvl) + 4) % 4;
    cnt = ena && (d == 1 || d == 3);
    {a_in, b_in} = lvl;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("step", 32'(step), 32'(cnt && i == 6));
      clr = do_clr && (i == 5);
      err_clr = do_eclr && (i == 5);
    end
    mlvl = lvl;
    if (cnt) begin
      mdir = (d == 1);
      if (do_clr) mpos = 16'd0;
      else if (d == 1) mpos = mpos + 16'd1;
      else mpos = mpos - 16'd1;
    end else if (do_clr) begin
      mpos = 16'd0;
    end
    if (ena && d == 2) merr = 1'b1;
    else if (do_eclr) merr = 1'b0;
    check_outs("move");
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mpos = 16'd0;
    chk("clr_pos", 32'(pos), 32'(mpos));
  endtask

  task automatic eclr_pulse();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    merr = 1'b0;
    chk("errclr", 32'(err), 32'(merr));
  endtask

  task automatic glitch_a(input int len);
    a_in = ~a_in;
    repeat (len) @(negedge clk);
    a_in = ~a_in;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("glitch_step", 32'(step), 32'd0);
    end
    check_outs("glitch");
  endtask

  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_step"}, 32'(step), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'(merr));
    end
  endtask

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    clr = 1'b0;
    err_clr = 1'b0;
    a_in = 1'b1;
    b_in = 1'b1;
    mpos = 16'd0;
    mdir = 1'b0;
    merr = 1'b0;
    mlvl = 2'b11;

    // Reset with both phases high
    repeat (3) @(negedge clk);
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    rst = 1'b0;
    quiet(10, "init");
    check_outs("init");

    // 11 must be the tracked state: 11->10 is a forward step
    move(2'b10, 10, 1'b0, 1'b0);
    move(2'b00, 10, 1'b0, 1'b0);
    clr_pulse();

    // Forward cycle from pos 0, then five reverse steps
    move(2'b01, 10, 1'b0, 1'b0);
    move(2'b11, 10, 1'b0, 1'b0);
    move(2'b10, 10, 1'b0, 1'b0);
    move(2'b00, 10, 1'b0, 1'b0);
    chk("fwd_pos4", 32'(pos), 32'd4);
    move(2'b10, 10, 1'b0, 1'b0);
    move(2'b11, 10, 1'b0, 1'b0);
    move(2'b01, 10, 1'b0, 1'b0);
    move(2'b00, 10, 1'b0, 1'b0);
    move(2'b10, 10, 1'b0, 1'b0);
    chk("rev_wrap", 32'(pos), 32'hffff);
    chk("rev_dir", 32'(dir), 32'd0);

    // Short pulse on A is rejected
    glitch_a(3);

    // Illegal 00->11 sets sticky err
    move(2'b00, 10, 1'b0, 1'b0);
    move(2'b11, 10, 1'b0, 1'b0);
    quiet(8, "sticky");
    eclr_pulse();

    // clr together with a forward step; err_clr with a new illegal
    move(2'b10, 10, 1'b1, 1'b0);
    chk("clr_step_pos", 32'(pos), 32'd0);
    move(2'b01, 10, 1'b0, 1'b1);
    chk("eclr_set_wins", 32'(err), 32'd1);
    eclr_pulse();

    // Disabled decoding, then resume
    ena = 1'b0;
    move(2'b11, 10, 1'b0, 1'b0);
    move(2'b10, 10, 1'b0, 1'b0);
    move(2'b00, 10, 1'b0, 1'b0);
    ena = 1'b1;
    move(2'b01, 10, 1'b0, 1'b0);
    chk("ena_resume", 32'(pos), 32'd1);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pos", 32'(pos), 32'd0);
    chk("arst_dir", 32'(dir), 32'd0);
    chk("arst_step", 32'(step), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mpos = 16'd0;
    mdir = 1'b0;
    merr = 1'b0;
    mlvl = {a_in, b_in};
    quiet(10, "reinit");

    // Random walk including illegal jumps and occasional error clears
    for (int k = 0; k < 40; k++) begin
      move(2'($urandom), int'($urandom_range(7, 12)), 1'b0, 1'b0);
      if (merr && ($urandom_range(0, 3) == 0)) eclr_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_dec.md
# quad_dec

Quadrature decoder for the counter path. It receives the two-phase Gray-coded A/B signals produced by an encoder or a quadrature generator, and synchronizes and glitch-filters them. It decodes each valid phase transition into an up or down step and accumulates the signed motion in a wrapping position counter. This block is the receiving end of the up/down counting interface: it reconstructs count and direction from the phase lines rather than taking an explicit `up` input.

## Interface
- CNT_W, 16, width of position counter
- SYNC_STAGES, 2, synchronizer flops per input (minimum 2)
- FILT_LEN, 4, consecutive stable cycles required before a filtered input changes (minimum 1)

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- ena  in  1  decode enable; when 0, state is tracked but pos is not changed and no error is flagged
- a_in  in  1  phase A, asynchronous to clk
- b_in  in  1  phase B, asynchronous to clk
- clr  in  1  synchronous clear of pos
- err_clr  in  1  synchronous clear of err
- pos  out  CNT_W  position count, unsigned, wraps
- step  out  1  one-cycle pulse per valid counted transition
- dir  out  1  direction of last counted step (1 = up, 0 = down)
- err  out  1  sticky illegal-transition flag

## Operation
- **Reset (rst=1):** all synchronizer flops, filter counters, filtered state {af,bf}, previous state {ap,bp}, pos, step, dir and err are cleared to 0. The FSM enters INIT.
- **Synchronizer:** an SYNC_STAGES-deep flop chain per input. Its outputs are sa and sb.
- **Filter, per channel:**
  - If s equals f, the filter counter is cleared to 0.
  - Else if the counter equals FILT_LEN-1, f is loaded with s and the counter is cleared.
  - Otherwise the counter increments.
- **FSM INIT:**
  - Lasts SYNC_STAGES+FILT_LEN cycles after reset release, timed by an internal counter.
  - af, bf, ap and bp load sa and sb directly with no filtering.
  - There is no counting, no step and no err.
  - The FSM then moves to RUN. It is never re-entered except by rst.
- **FSM RUN, each cycle:** {ap,bp} is updated to {af,bf}. The transition from {ap,bp} to {af,bf} is classified as follows:
  - **No change:** nothing happens.
  - **Forward (up):** 00→01, 01→11, 11→10, 10→00. Result: pos+1, dir=1, step=1.
  - **Reverse (down):** 00→10, 10→11, 11→01, 01→00. Result: pos-1, dir=0, step=1.
  - **Both bits changed:** illegal. Result: err=1; pos, dir and step are unchanged.
- **ena=0:** classification is suppressed. {ap,bp} still tracks {af,bf}, so no step is counted when ena is re-enabled.
- **Arithmetic:** pos is modulo 2^CNT_W. Up from all-ones gives 0; down from 0 gives all-ones.
- **clr priority:** clr=1 forces pos=0 in that cycle regardless of any step. step and dir still reflect the transition.
- **err_clr:** clears err. If err_clr and a new illegal transition occur in the same cycle, err=1 (set wins).
- **Asynchronous reset mid-operation:** all outputs return to their reset values immediately and the FSM re-enters INIT.

## Timing
- **Edge 0:** the first rising clk edge that samples a new a_in/b_in level.
- **Filtered state change:** af/bf change at edge SYNC_STAGES-1+FILT_LEN.
- **Outputs:** pos, step and dir update at edge SYNC_STAGES+FILT_LEN. With default parameters this is edge 6.
- **step:** high for exactly one cycle per counted transition. It is never high in INIT.
- **Glitch rejection:** a pulse on one input shorter than FILT_LEN cycles, measured after synchronization, produces no change in af/bf, pos or err.
- **Maximum count rate:** one transition per FILT_LEN cycles per channel. Closer spacing is filtered, or flagged if both filtered bits change in the same cycle.
- **Output registers:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset:** rst pulsed with a_in=b_in=1. Required response:
  - pos=0, err=0, step=0.
  - After SYNC_STAGES+FILT_LEN cycles the FSM is in RUN with {ap,bp}=11.
  - No step or err is produced.
- **Forward and reverse sequences:** forward sequence 00→01→11→10→00 with each level held 10 cycles, from pos=0. Required response:
  - pos=4, dir=1, four step pulses.
  - Each pulse occurs 6 cycles after the corresponding input edge.
  - Then reverse ×5 gives pos=0xFFFF and dir=0.
- **Glitch and illegal transition:** a 3-cycle pulse on a_in (FILT_LEN=4) gives no step and pos unchanged. Switching a_in and b_in together from 00 to 11 gives err=1 with pos unchanged. err stays 1 until err_clr is asserted.
- **Same-cycle priority:** clr asserted in the same cycle as a forward step gives pos=0, step=1, dir=1. err_clr asserted in the same cycle as a new illegal transition gives err=1.
- **ena and mid-operation reset:**
  - With ena=0, three forward transitions leave pos unchanged and produce no step.
  - After ena returns to 1, one forward transition gives pos+1.
  - rst asserted mid-sequence clears pos to 0 within the same cycle, asynchronously.
